// File: rtl/mux_rr_if.sv
// mux_rr_if: handshake bundle between the producers, mux_rr and the consumer.
//   in_valid/in_data/in_last/in_ready : per-channel producer handshake, channel i data at [i*WIDTH +: WIDTH]
//   out_valid/out_data/out_sel/out_last/out_ready : merged consumer handshake
//   slave modport  : mux side (drives in_ready and out_*)
//   master modport : environment side (drives in_* and out_ready)
interface mux_rr_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_last;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_last;
    logic                      out_ready;
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );
endinterface

// File: rtl/mux_rr.sv
// mux_rr: N-channel registered round-robin multiplexer with valid/ready handshakes.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : mux_rr_if.slave (producer channels in, single registered output)
//   Optional packet lock enabled by defining MUX_RR_LOCK_EN.
module mux_rr #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input logic     clock,
    input logic     reset,
    mux_rr_if.slave bus
);
    localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] idx;
    logic             found;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;
`ifdef MUX_RR_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_ch;
`endif
    assign load_en    = !bus.out_valid || bus.out_ready;
    assign xfer       = !reset && found && load_en;
    assign grant_data = bus.in_data[grant*WIDTH +: WIDTH];
    // Search ptr+1, ptr+2, ... wrapping; the first valid channel wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = SEL_W'((int'(ptr) + k) % CHANNELS);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
`ifdef MUX_RR_LOCK_EN
        // An open packet pins the grant to its channel, even while it idles.
        if (locked) begin
            found = bus.in_valid[lock_ch];
            grant = lock_ch;
        end
`endif
    end
    always_comb begin
        bus.in_ready        = '0;
        bus.in_ready[grant] = xfer;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            bus.out_last  <= 1'b0;
            ptr           <= SEL_W'(CHANNELS - 1);
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= grant_data;
            bus.out_sel   <= grant;
            bus.out_last  <= bus.in_last[grant];
            ptr           <= grant;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
`ifdef MUX_RR_LOCK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            locked  <= !bus.in_last[grant];
            lock_ch <= grant;
        end
    end
`endif
endmodule

// File: tb/tb_mux_rr.sv
// tb_mux_rr: self-checking bench for mux_rr with directed scenarios and a randomized run.
module tb_mux_rr;
    localparam int W = 16;
    localparam int C = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0;
    int total  = 0;
    // Reference state: output word plus last-granted channel and open packet.
    logic         m_ov     = 1'b0;
    logic [W-1:0] m_data   = '0;
    int           m_sel    = 0;
    logic         m_last   = 1'b0;
    int           m_ptr    = C - 1;
    logic         m_locked = 1'b0;
    int           m_lk     = 0;

    mux_rr_if #(.WIDTH(W), .CHANNELS(C)) bus ();
    mux_rr #(.WIDTH(W), .CHANNELS(C)) dut (.clock(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic int model_grant();
        if (m_locked) return bus.in_valid[m_lk] ? m_lk : -1;
        for (int k = 1; k <= C; k++)
            if (bus.in_valid[(m_ptr + k) % C]) return (m_ptr + k) % C;
        return -1;
    endfunction

    function automatic logic [C-1:0] model_ready();
        int g;
        logic [C-1:0] r;
        g = model_grant();
        r = '0;
        if (!rst && (!m_ov || bus.out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        int g;
        logic ld;
        logic [W-1:0] d;
        logic l;
        g  = model_grant();
        ld = !m_ov || bus.out_ready;
        d  = (g >= 0) ? bus.in_data[g*W +: W] : '0;
        l  = (g >= 0) ? bus.in_last[g] : 1'b0;
        @(posedge clk);
        if (rst) begin
            m_ov = 0; m_data = '0; m_sel = 0; m_last = 0; m_ptr = C - 1; m_locked = 0; m_lk = 0;
        end else if (g >= 0 && ld) begin
            m_ov = 1; m_data = d; m_sel = g; m_last = l; m_ptr = g;
`ifdef MUX_RR_LOCK_EN
            m_locked = !l; m_lk = g;
`endif
        end else if (m_ov && bus.out_ready) begin
            m_ov = 0;
        end
        #1;
    endtask

    task automatic set_rotation_data();
        for (int i = 0; i < C; i++) bus.in_data[i*W +: W] = W'((i + 1) * 'h1111);
    endtask

    task automatic test_reset();
        rst = 1; bus.in_valid = '1; bus.in_last = '1; bus.out_ready = 1;
        set_rotation_data();
        repeat (2) begin
            #1;
            total++;
            if (bus.in_ready !== 4'b0000) $display("FAIL reset_in_ready got %b want 0000", bus.in_ready); else passed++;
            tick();
            total++;
            if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
        end
        total++;
        if (bus.out_data !== 16'h0 || bus.out_sel !== 2'd0 || bus.out_last !== 1'b0)
            $display("FAIL reset_out_regs got data=%h sel=%0d last=%b want 0/0/0", bus.out_data, bus.out_sel, bus.out_last);
        else passed++;
        rst = 0; #1;
        total++;
        if (bus.in_ready !== 4'b0001) $display("FAIL release_in_ready got %b want 0001", bus.in_ready); else passed++;
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0) $display("FAIL release_first got v=%b sel=%0d want 1/0", bus.out_valid, bus.out_sel); else passed++;
    endtask

    task automatic test_rotation();
        int seq [5] = '{0, 1, 2, 3, 0};
        rst = 1; tick(); rst = 0;
        bus.in_valid = '1; bus.in_last = '1; bus.out_ready = 1;
        set_rotation_data();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(seq[i]) || bus.out_data !== W'((seq[i] + 1) * 'h1111))
                $display("FAIL rotation[%0d] got v=%b sel=%0d data=%h want 1/%0d/%h", i, bus.out_valid, bus.out_sel, bus.out_data, seq[i], W'((seq[i] + 1) * 'h1111));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 0;
        repeat (3) begin
            #1;
            total++;
            if (bus.in_ready !== 4'b0000) $display("FAIL bp_in_ready got %b want 0000", bus.in_ready); else passed++;
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 16'h1111)
                $display("FAIL bp_hold got v=%b sel=%0d data=%h want 1/0/1111", bus.out_valid, bus.out_sel, bus.out_data);
            else passed++;
        end
        bus.out_ready = 1; #1;
        total++;
        if (bus.in_ready !== 4'b0010) $display("FAIL bp_release_ready got %b want 0010", bus.in_ready); else passed++;
        tick();
        total++;
        if (bus.out_sel !== 2'd1 || bus.out_data !== 16'h2222) $display("FAIL bp_release_word got sel=%0d data=%h want 1/2222", bus.out_sel, bus.out_data); else passed++;
    endtask

    task automatic test_single();
        logic [W-1:0] d;
        bus.in_valid = 4'b0100;
        repeat (4) begin
            d = W'($urandom);
            bus.in_data[2*W +: W] = d;
            #1;
            total++;
            if (bus.in_ready !== 4'b0100) $display("FAIL single_ready got %b want 0100", bus.in_ready); else passed++;
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== d)
                $display("FAIL single_word got v=%b sel=%0d data=%h want 1/2/%h", bus.out_valid, bus.out_sel, bus.out_data, d);
            else passed++;
        end
        bus.in_valid = '0;
        tick();
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL single_drain got v=%b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_lock();
`ifdef MUX_RR_LOCK_EN
        int exp_sel [] = '{1, 1, 1, 2, 0};
`else
        int exp_sel [] = '{1, 2, 0, 1};
`endif
        int n1 = 0;
        logic [C-1:0] rdy;
        rst = 1; tick(); rst = 0;
        bus.out_ready = 1;
        set_rotation_data();
        for (int t = 0; t < exp_sel.size(); t++) begin
            bus.in_valid = (t == 0) ? 4'b0010 : 4'b0111;
            bus.in_last  = {1'b1, 1'b1, n1 >= 2, 1'b1};
            #1;
            rdy = bus.in_ready;
            tick();
            if (rdy[1]) n1++;
            total++;
            if (bus.out_sel !== 2'(exp_sel[t]) || bus.out_last !== m_last)
                $display("FAIL lock[%0d] got sel=%0d last=%b want %0d/%b", t, bus.out_sel, bus.out_last, exp_sel[t], m_last);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        rst = 1; tick(); rst = 0;
        bus.in_valid = 4'b1000; bus.in_last = 4'b0000; bus.out_ready = 1;
        tick();
        total++;
        if (bus.out_sel !== 2'd3 || bus.out_valid !== 1'b1) $display("FAIL rmid_lock got sel=%0d v=%b want 3/1", bus.out_sel, bus.out_valid); else passed++;
        bus.out_ready = 0; bus.in_valid = '1;
        tick();
        rst = 1; #1;
        total++;
        if (bus.in_ready !== 4'b0000) $display("FAIL rmid_ready got %b want 0000", bus.in_ready); else passed++;
        tick();
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL rmid_discard got v=%b want 0", bus.out_valid); else passed++;
        rst = 0; bus.out_ready = 1; bus.in_last = '1; #1;
        total++;
        if (bus.in_ready !== 4'b0001) $display("FAIL rmid_unlock got %b want 0001", bus.in_ready); else passed++;
        tick();
        total++;
        if (bus.out_sel !== 2'd0) $display("FAIL rmid_first got sel=%0d want 0", bus.out_sel); else passed++;
    endtask

    task automatic test_random();
        logic [C-1:0] er;
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            bus.in_valid  = C'($urandom);
            bus.in_data   = {$urandom, $urandom};
            bus.in_last   = C'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            er = model_ready();
            total++;
            if (bus.in_ready !== er) $display("FAIL rand_ready[%0d] got %b want %b", i, bus.in_ready, er); else passed++;
            tick();
            total++;
            if (bus.out_valid !== m_ov) $display("FAIL rand_valid[%0d] got %b want %b", i, bus.out_valid, m_ov); else passed++;
            if (m_ov) begin
                total++;
                if (bus.out_data !== m_data || bus.out_sel !== 2'(m_sel) || bus.out_last !== m_last)
                    $display("FAIL rand_word[%0d] got %h/%0d/%b want %h/%0d/%b", i, bus.out_data, bus.out_sel, bus.out_last, m_data, m_sel, m_last);
                else passed++;
            end
        end
        rst = 0;
    endtask

    initial begin
        bus.in_valid = '0; bus.in_data = '0; bus.in_last = '0; bus.out_ready = 1'b0;
        test_reset();
        test_rotation();
        test_backpressure();
        test_single();
        test_lock();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mux_rr.md
# mux_rr

Parametrised N-channel, W-bit registered round-robin multiplexer with valid/ready handshakes on every port. It is the sequential successor of the fixed 16-bit two-way mux in the chip library. Instead of a caller-driven select, it arbitrates fairly among requesting channels and registers the winner's word. Its job is to merge several producer streams (ALU results, memory read returns, I/O words) onto one consumer bus.

## Interface
- `WIDTH`, 16, data word width in bits (≥1).
- `CHANNELS`, 4, number of input channels (≥1).
- `SEL_W` is derived, not overridable: `$clog2(CHANNELS)`, minimum 1.

- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input CHANNELS: per-channel word-present flag.
- `in_data` input CHANNELS*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_last` input CHANNELS: per-channel end-of-packet flag, qualified by `in_valid`.
- `in_ready` output CHANNELS: per-channel accept flag; one-hot or zero.
- `out_valid` output 1: output register holds a word.
- `out_data` output WIDTH: registered winning word.
- `out_sel` output SEL_W: index of the channel that supplied `out_data`.
- `out_last` output 1: registered `in_last` of that word.
- `out_ready` input 1: consumer accepts the output word.

## Operation
- Output stage is a single register.
  - `load_en = !out_valid || out_ready`.
- Arbitration is combinational and round-robin.
  - Search starts at `ptr+1` mod CHANNELS, where `ptr` is the last granted channel.
  - The first channel found with `in_valid=1` is the grant.
  - `in_ready[g] = load_en`; all other `in_ready` bits are 0.
  - `in_ready` may depend on `in_valid`; producers must not make `in_valid` depend on `in_ready`.
- Transfer on channel i happens when `in_valid[i] && in_ready[i]`. On a transfer:
  - The output register loads data, sel and last.
  - `out_valid` is set to 1.
  - `ptr` is set to i.
- No transfer while `out_valid && out_ready`: `out_valid` clears.
- No transfer while `out_valid && !out_ready`: the output register and `out_valid` hold unchanged.
- No channel valid: no grant, `ptr` unchanged.
- `CHANNELS=1`: grant is always channel 0; `out_sel` is always 0.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_sel=0`, `out_last=0`.
  - `ptr=CHANNELS-1`, so channel 0 has the highest priority on the first arbitration.
  - Lock state cleared (see Configuration).
  - `in_ready` is combinational. In the reset cycle itself it is forced to all zeros.
- Latency: a word accepted at edge n is presented on `out_*` after edge n, i.e. one cycle.
- Throughput: one word per cycle when `out_ready` is held at 1.
- Backpressure: `out_ready=0` with `out_valid=1` drives all `in_ready` to 0 in the same cycle. Acceptance resumes in the cycle `out_ready` returns to 1, and accept and drain occur on the same edge.
- Simultaneous drain and load: the new word replaces the old one; `out_valid` stays 1.
- `reset` asserted mid-stream wins over every other event at that edge; the in-flight output word is discarded.

## Configuration
- `MUX_RR_LOCK_EN` (define).
  - **Defined:** packet lock.
    - Accepting a word with `in_last=0` from channel k sets `locked=1`, `lock_ch=k`.
    - While locked, only channel k may be granted, even if k is idle and others are valid.
    - Accepting a word from k with `in_last=1` clears `locked`.
    - `ptr` advances normally, so after unlock the search starts at k+1.
  - **Undefined:** no lock state. Arbitration runs every word; `in_last` is only forwarded to `out_last`.

## Test plan
- **Reset release:** hold `reset=1` for 2 cycles with all `in_valid=1` → `in_ready=0000` and `out_valid=0` during reset. First accept after release is ch0: `out_sel=0`.
- **Fair rotation:** WIDTH=16, CHANNELS=4, ch0..3 data 0x1111/0x2222/0x3333/0x4444, all valid, `out_ready=1` → `out_sel` sequence 0,1,2,3,0 on consecutive cycles with matching data.
- **Backpressure:** mid-rotation, drop `out_ready` for 3 cycles → `out_data` and `out_sel` hold, `in_ready=0000`. On release, the next accepted channel is `ptr+1` and no word is lost or duplicated.
- **Single requester:** only ch2 valid → ch2 is accepted every cycle, `out_sel=2`, throughput 1/cycle. Dropping `in_valid[2]` clears `out_valid` one cycle after the last drain.
- **Lock:** cycle 0 only ch1 valid (`last=0`); from cycle 1 ch0, ch1, ch2 all valid, ch1 sending `last=0,1`.
  - With `MUX_RR_LOCK_EN`: `out_sel` = 1,1,1(last),2,0.
  - Without it: `out_sel` = 1,2,0,1.
- **Reset mid-packet:** with `MUX_RR_LOCK_EN`, ch3 is locked and `out_valid=1`, then assert `reset` for 1 cycle → `out_valid=0`, lock cleared, next grant is the lowest-index valid channel starting at ch0.
